uart_boot_loader: RTL

//   Boot-time loader inside the core, downstream of uart_rx and upstream of uart_tx.

---
 rtl/uart_boot_loader_pkg.sv | 28 ++
 rtl/uart_boot_loader_packer.sv | 48 ++++
 rtl/uart_boot_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: loader states, ACK byte,
// and a helper that tells whether a state accepts host bytes.
package loader_pkg;

    localparam logic [7:0] ACK_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        P_HDR    = 3'd0,
        P_BODY   = 3'd1,
        ACK_SEND = 3'd2,
        ACK_WAIT = 3'd3,
        D_HDR    = 3'd4,
        D_BODY   = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } loader_state_t;

    // The host may only stream bytes while a header or body word is expected.
    function automatic logic accepts_bytes(input loader_state_t s);
        logic ok;
        case (s)
            P_HDR, P_BODY, D_HDR, D_BODY: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/uart_boot_loader_packer.sv
// Packs received bytes MSB first into 32-bit words; the completed word is presented
// combinationally alongside the 4th byte so the loader can register the write.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [1:0]  phase_q;
    logic [1:0]  phase_d;

    assign word       = {acc_q[23:0], rx_data};
    assign word_valid = rx_valid & ~clear & (phase_q == 2'd3);

    // Shift in accepted bytes; a clear drops any partial word.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        if (clear) begin
            phase_d = 2'd0;
        end else if (rx_valid) begin
            acc_d   = word;
            phase_d = phase_q + 2'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    // Accumulator and byte-phase registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= 32'd0;
            phase_q <= 2'd0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a length-prefixed program image into imem, ACKs the host,
// then a length-prefixed data image into dmem, and finally raises load_done.
module uart_boot_loader #(
    parameter int         IMEM_AW  = 14,
    parameter int         DMEM_AW  = 11,
    parameter logic [7:0] ACK_BYTE = 8'hAA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_ferr,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic               rts,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               load_done,
    output logic               load_err
);
    import loader_pkg::*;

    // One counter serves both phases, one bit wider than the larger address so a
    // full-size image length never wraps.
    localparam int          CW         = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
    localparam logic [31:0] IMEM_LIMIT = 32'd1 << IMEM_AW;
    localparam logic [31:0] DMEM_LIMIT = 32'd1 << DMEM_AW;

    loader_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      len_q, len_d;
    logic               seen_busy_q, seen_busy_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               rts_q, rts_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;

    logic               accepting_s;
    logic               byte_err_s;
    logic               pk_clear_s;
    logic               pk_valid_s;
    logic [31:0]        word_s;
    logic               word_valid_s;

    assign accepting_s = accepts_bytes(state_q);
    assign byte_err_s  = rx_valid & rx_ferr;
    assign pk_clear_s  = ~accepting_s;
    assign pk_valid_s  = rx_valid & ~rx_ferr & accepting_s;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear_s),
        .rx_valid   (pk_valid_s),
        .rx_data    (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Loader FSM: next state, counters and the registered memory/UART outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        seen_busy_d  = seen_busy_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;

        case (state_q)
            P_HDR: begin
                if (byte_err_s) begin
                    state_d = ERR;
                end else if (word_valid_s) begin
                    if (word_s == 32'd0) begin
                        state_d = ACK_SEND;
                    end else if (word_s > IMEM_LIMIT) begin
                        state_d = ERR;
                    end else begin
                        len_d   = word_s[CW-1:0];
                        cnt_d   = {CW{1'b0}};
                        state_d = P_BODY;
                    end
                end else begin
                    state_d = P_HDR;
                end
            end
            P_BODY: begin
                if (byte_err_s) begin
                    state_d = ERR;
                end else if (word_valid_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q[IMEM_AW-1:0];
                    imem_wdata_d = word_s;
                    if (cnt_q == len_q - CW'(1)) begin
                        state_d = ACK_SEND;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = P_BODY;
                end
            end
            ACK_SEND: begin
                if (rx_valid) begin
                    state_d = ERR;
                end else if (!tx_busy) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = ACK_BYTE;
                    seen_busy_d = 1'b0;
                    state_d     = ACK_WAIT;
                end else begin
                    state_d = ACK_SEND;
                end
            end
            ACK_WAIT: begin
                // The transmitter must be seen busy before its idle counts as done.
                if (rx_valid) begin
                    state_d = ERR;
                end else if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d = D_HDR;
                end else begin
                    state_d = ACK_WAIT;
                end
            end
            D_HDR: begin
                if (byte_err_s) begin
                    state_d = ERR;
                end else if (word_valid_s) begin
                    if (word_s == 32'd0) begin
                        state_d = DONE;
                    end else if (word_s > DMEM_LIMIT) begin
                        state_d = ERR;
                    end else begin
                        len_d   = word_s[CW-1:0];
                        cnt_d   = {CW{1'b0}};
                        state_d = D_BODY;
                    end
                end else begin
                    state_d = D_HDR;
                end
            end
            D_BODY: begin
                if (byte_err_s) begin
                    state_d = ERR;
                end else if (word_valid_s) begin
                    dmem_we_d    = 1'b1;
                    dmem_addr_d  = cnt_q[DMEM_AW-1:0];
                    dmem_wdata_d = word_s;
                    if (cnt_q == len_q - CW'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = D_BODY;
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase

        rts_d       = accepts_bytes(state_d);
        load_done_d = (state_d == DONE);
        load_err_d  = (state_d == ERR);
    end

    // State and output registers; reset drops any in-flight strobe at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= P_HDR;
            cnt_q        <= {CW{1'b0}};
            len_q        <= {CW{1'b0}};
            seen_busy_q  <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {IMEM_AW{1'b0}};
            imem_wdata_q <= 32'd0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= {DMEM_AW{1'b0}};
            dmem_wdata_q <= 32'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            rts_q        <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            seen_busy_q  <= seen_busy_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            rts_q        <= rts_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign rts        = rts_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule
